// File: rtl/nn_pkg.sv
// Shared constants and types for the neural-network host port.
package nn_pkg;

    localparam int NN_ADDR_W = 6;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_CLRERR = 2'b10;
    localparam logic [1:0] OP_NOP    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/nn_strb_sync.sv
// Two-flop synchronizer for the asynchronous host strobe, followed by a
// registered copy used to produce one-cycle rise and fall pulses.
module nn_strb_sync (
    input  logic clk,
    input  logic rst,
    input  logic strb_async,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Synchronizer chain plus the previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= strb_async;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/nn_host_port.sv
// Host byte protocol front end: decodes framed command bytes into core
// register writes and start pulses, and latches core results for the pads.
module nn_host_port
    import nn_pkg::*;
#(
    parameter int ADDR_W = NN_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        host_data,
    input  logic              host_strb,
    output logic              host_ack,
    output logic              ld_we,
    output logic [ADDR_W-1:0] ld_addr,
    output logic [7:0]        ld_data,
    output logic              start,
    input  logic              core_busy,
    input  logic [7:0]        core_res,
    input  logic              core_res_vld,
    output logic [7:0]        dout,
    output logic              err
);

    logic              strb_rise;
    logic              strb_fall;
    state_t            state;
    logic [7:0]        count;
    logic [ADDR_W-1:0] addr;

    nn_strb_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .strb_async (host_strb),
        .rise       (strb_rise),
        .fall       (strb_fall)
    );

    // Frame FSM: one byte is consumed per synchronized strobe rise; the
    // write and start strobes are single-cycle pulses launched with the ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 8'd0;
            addr     <= '0;
            host_ack <= 1'b0;
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_data  <= 8'd0;
            start    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ld_we <= 1'b0;
            start <= 1'b0;
            if (strb_fall) begin
                host_ack <= 1'b0;
            end
            if (strb_rise && ena) begin
                host_ack <= 1'b1;
                case (state)
                    IDLE: begin
                        case (host_data[7:6])
                            OP_WRITE: begin
                                addr  <= ADDR_W'(host_data[5:0]);
                                state <= LEN;
                            end
                            OP_START: begin
                                if (!core_busy) begin
                                    start <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            OP_CLRERR: err <= 1'b0;
                            default: ;
                        endcase
                    end
                    LEN: begin
                        if (host_data == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            count <= host_data;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        ld_we   <= 1'b1;
                        ld_addr <= addr;
                        ld_data <= host_data;
                        addr    <= addr + ADDR_W'(1);
                        count   <= count - 8'd1;
                        if (count == 8'd1) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Result latch runs independently of the host-side frame handling
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'd0;
        end else if (core_res_vld) begin
            dout <= core_res;
        end
    end

endmodule
